// File: rtl/execute_stage.sv
// execute_stage: RV32IM execute stage with a 32-step iterative MDU, registering results for the memory stage
module execute_stage #(
  parameter int XLEN = 32,
  parameter bit MDU_ENABLE = 1'b1,
  parameter logic [31:0] NOP_INST = 32'h13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     exe_inst,
  input  logic [XLEN-1:0] exe_pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            freeze_cpu,
  output logic [31:0]     mem_inst,
  output logic [XLEN-1:0] exe_result,
  output logic [XLEN-1:0] mem_addr,
  output logic            exe_busy
);
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state, state_nx;
  logic [6:0] opc;
  logic [2:0] f3, mf;
  logic is_op, is_mext, is_m, sa, sb, neg_q, neg_r;
  logic [31:0] i_imm, s_imm, u_imm, op_b, alu, sra_r, res, addr, ua, ub, b, q, r, mdu_res;
  logic [4:0] sh, cnt;
  logic [63:0] p, p_nx, prod;
  logic [32:0] sum, r33, diff;
  assign opc = exe_inst[6:0];
  assign f3 = exe_inst[14:12];
  assign is_op = opc == OP_REG;
  assign is_mext = is_op && exe_inst[31:25] == 7'b0000001;
  assign is_m = MDU_ENABLE && is_mext;
  assign exe_busy = (state == IDLE && is_m) || state == BUSY;
  assign i_imm = {{20{exe_inst[31]}}, exe_inst[31:20]};
  assign s_imm = {{20{exe_inst[31]}}, exe_inst[31:25], exe_inst[11:7]};
  assign u_imm = {exe_inst[31:12], 12'b0};
  assign op_b = is_op ? rs2_data : i_imm;
  assign sh = op_b[4:0];
  assign sra_r = $signed(rs1_data) >>> sh;
  always_comb begin
    alu = '0;
    case (f3)
      3'd0: alu = (is_op && exe_inst[30]) ? rs1_data - op_b : rs1_data + op_b;
      3'd1: alu = rs1_data << sh;
      3'd2: alu = {31'b0, $signed(rs1_data) < $signed(op_b)};
      3'd3: alu = {31'b0, rs1_data < op_b};
      3'd4: alu = rs1_data ^ op_b;
      3'd5: alu = exe_inst[30] ? sra_r : rs1_data >> sh;
      3'd6: alu = rs1_data | op_b;
      default: alu = rs1_data & op_b;
    endcase
  end
  assign res = opc == OP_LUI ? u_imm :
               opc == OP_AUIPC ? exe_pc + u_imm :
               (opc == OP_JAL || opc == OP_JALR) ? exe_pc + 32'd4 :
               (opc == OP_IMM || (is_op && !is_mext)) ? alu :
               opc == OP_STORE ? rs2_data : '0;
  assign addr = opc == OP_LOAD ? rs1_data + i_imm : opc == OP_STORE ? rs1_data + s_imm : '0;
  // Signed ops run on magnitudes; the sign is re-applied when the result is read out
  assign sa = rs1_data[31] && (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd6);
  assign sb = rs2_data[31] && (f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd6);
  assign ua = sa ? -rs1_data : rs1_data;
  assign ub = sb ? -rs2_data : rs2_data;
  assign sum = {1'b0, p[63:32]} + (p[0] ? {1'b0, b} : 33'd0);
  assign r33 = p[63:31];
  assign diff = r33 - {1'b0, b};
  assign p_nx = mf[2] ? {(diff[32] ? p[62:31] : diff[31:0]), p[30:0], ~diff[32]} : {sum, p[31:1]};
  assign prod = neg_q ? -p : p;
  assign q = neg_q ? -p[31:0] : p[31:0];
  assign r = neg_r ? -p[63:32] : p[63:32];
  assign mdu_res = mf[2] ? (mf[1] ? r : q) : (mf[1:0] == 2'd0 ? prod[31:0] : prod[63:32]);
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? (is_m ? BUSY : IDLE) :
               state == BUSY ? (cnt == 5'd31 ? DONE : BUSY) :
               (freeze_cpu ? DONE : IDLE);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_inst <= NOP_INST;
      exe_result <= '0;
      mem_addr <= '0;
      cnt <= '0;
      p <= '0;
      b <= '0;
      mf <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      if (state == IDLE && is_m) begin
        p <= {32'b0, ua};
        b <= ub;
        mf <= f3;
        neg_q <= (sa ^ sb) && !(f3[2] && rs2_data == '0);
        neg_r <= sa;
        cnt <= '0;
      end else if (state == BUSY) begin
        p <= p_nx;
        cnt <= cnt + 5'd1;
      end
      if (!freeze_cpu) begin
        mem_inst <= exe_busy ? NOP_INST : exe_inst;
        exe_result <= state == DONE ? mdu_res : exe_busy ? '0 : res;
        mem_addr <= (exe_busy || state == DONE) ? '0 : addr;
      end
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// tb_execute_stage: directed vectors for execute_stage checked against an arithmetic reference model
module tb_execute_stage;
  logic clk = 1'b0, rst = 1'b1, freeze_cpu = 1'b0;
  logic [31:0] exe_inst = 32'h13, exe_pc = '0, rs1_data = '0, rs2_data = '0;
  logic [31:0] mem_inst, exe_result, mem_addr;
  logic exe_busy;
  int checks = 0, errors = 0;
  logic [31:0] e_inst, e_res, e_addr;
  int mc = 0;
  typedef struct {logic [31:0] inst, pc, a, b, res, addr;} sv_t;
  typedef struct {logic [31:0] inst, a, b, res; int hold;} mv_t;
  sv_t sv[$];
  mv_t mv[$];

  execute_stage dut (.clk(clk), .rst(rst), .exe_inst(exe_inst), .exe_pc(exe_pc), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .freeze_cpu(freeze_cpu), .mem_inst(mem_inst), .exe_result(exe_result),
    .mem_addr(mem_addr), .exe_busy(exe_busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [2:0] f);
    return {f7, 5'd2, 5'd1, f, 5'd3, 7'h33};
  endfunction
  function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [2:0] f, input logic [6:0] op);
    return {imm, 5'd0, f, 5'd2, op};
  endfunction
  function automatic logic is_m(input logic [31:0] i);
    return i[6:0] == 7'h33 && i[31:25] == 7'h01;
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] pr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    pr = f == 3'd1 ? sa * sb : f == 3'd2 ? sa * ub : ua * ub;
    if (!f[2]) return f == 3'd0 ? pr[31:0] : pr[63:32];
    if (b == 0) return f[1] ? a : 32'hFFFFFFFF;
    if (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return f[1] ? 32'h0 : 32'h80000000;
    if (f[0]) return f[1] ? a % b : a / b;
    if (f[1]) return $signed(a) % $signed(b);
    return $signed(a) / $signed(b);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [31:0] inst, input logic [31:0] pc,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ii, ob;
    logic [4:0] s;
    ii = {{20{inst[31]}}, inst[31:20]};
    ob = inst[5] ? b : ii;
    s = ob[4:0];
    case (inst[6:0])
      7'h37: return {inst[31:12], 12'b0};
      7'h17: return pc + {inst[31:12], 12'b0};
      7'h6f, 7'h67: return pc + 4;
      7'h23: return b;
      7'h13, 7'h33: begin
        if (inst[6:0] == 7'h33 && inst[31:25] == 7'h01) return 0;
        case (inst[14:12])
          3'd0: return (inst[5] && inst[30]) ? a - ob : a + ob;
          3'd1: return a << s;
          3'd2: return ($signed(a) < $signed(ob)) ? 1 : 0;
          3'd3: return (a < ob) ? 1 : 0;
          3'd4: return a ^ ob;
          3'd5: begin
            if (inst[30]) return $signed(a) >>> s;
            return a >> s;
          end
          3'd6: return a | ob;
          default: return a & ob;
        endcase
      end
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] ref_addr(input logic [31:0] inst, input logic [31:0] a);
    if (inst[6:0] == 7'h03) return a + {{20{inst[31]}}, inst[31:20]};
    if (inst[6:0] == 7'h23) return a + {{20{inst[31]}}, inst[31:25], inst[11:7]};
    return 0;
  endfunction

  // Reference model: an M-op occupies execute for 33 cycles, then retires on the next unfrozen edge
  always @(posedge clk) begin
    if (rst) begin
      e_inst = 32'h13; e_res = 0; e_addr = 0; mc = 0;
    end else if (is_m(exe_inst) && mc >= 33) begin
      if (!freeze_cpu) begin
        e_inst = exe_inst; e_res = ref_mdu(exe_inst[14:12], rs1_data, rs2_data); e_addr = 0; mc = 0;
      end
    end else if (is_m(exe_inst)) begin
      mc++;
      if (!freeze_cpu) begin
        e_inst = 32'h13; e_res = 0; e_addr = 0;
      end
    end else if (!freeze_cpu) begin
      e_inst = exe_inst; e_res = ref_alu(exe_inst, exe_pc, rs1_data, rs2_data); e_addr = ref_addr(exe_inst, rs1_data);
    end
  end

  always @(posedge clk) begin
    #1;
    chk("mem_inst", mem_inst, e_inst);
    chk("exe_result", exe_result, e_res);
    chk("mem_addr", mem_addr, e_addr);
    chk("exe_busy", {31'b0, exe_busy}, {31'b0, is_m(exe_inst) && mc < 33});
  end

  task automatic sc(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    exe_inst = inst; exe_pc = pc; rs1_data = a; rs2_data = b;
    @(posedge clk);
    #2;
  endtask

  task automatic mop(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b, input int hold, output int n);
    @(negedge clk);
    exe_inst = inst; rs1_data = a; rs2_data = b;
    #1;
    n = 0;
    while (exe_busy && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    if (hold > 0) begin
      freeze_cpu = 1'b1;
      repeat (hold) begin
        @(posedge clk);
        #2;
        chk("hold_inst", mem_inst, 32'h13);
        chk("hold_res", exe_result, 32'h0);
      end
      @(negedge clk);
      freeze_cpu = 1'b0;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int n;
    logic [31:0] w;
    sv.push_back('{{20'h12345, 5'd2, 7'h37}, 32'h0, 32'h0, 32'h0, 32'h12345000, 32'h0});
    sv.push_back('{{20'h00001, 5'd2, 7'h17}, 32'h200, 32'h0, 32'h0, 32'h00001200, 32'h0});
    sv.push_back('{{20'h0, 5'd1, 7'h6f}, 32'h300, 32'h0, 32'h0, 32'h00000304, 32'h0});
    sv.push_back('{r_t(7'h20, 3'd0), 32'h0, 32'h5, 32'h7, 32'hFFFFFFFE, 32'h0});
    sv.push_back('{r_t(7'h00, 3'd2), 32'h0, 32'hFFFFFFFF, 32'h1, 32'h1, 32'h0});
    sv.push_back('{r_t(7'h00, 3'd3), 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0});
    sv.push_back('{r_t(7'h20, 3'd5), 32'h0, 32'h80000000, 32'h24, 32'hF8000000, 32'h0});
    sv.push_back('{r_t(7'h00, 3'd5), 32'h0, 32'h80000000, 32'h24, 32'h08000000, 32'h0});
    sv.push_back('{i_t(12'h003, 3'd1, 7'h13), 32'h0, 32'h1, 32'h0, 32'h8, 32'h0});
    sv.push_back('{i_t(12'h402, 3'd5, 7'h13), 32'h0, 32'h80000000, 32'h0, 32'hE0000000, 32'h0});
    sv.push_back('{i_t(12'hFFF, 3'd4, 7'h13), 32'h0, 32'h0F0F0F0F, 32'h0, 32'hF0F0F0F0, 32'h0});
    sv.push_back('{r_t(7'h00, 3'd6), 32'h0, 32'hF0, 32'h0F, 32'hFF, 32'h0});
    sv.push_back('{r_t(7'h00, 3'd7), 32'h0, 32'hF0, 32'h3C, 32'h30, 32'h0});
    sv.push_back('{{7'h0, 5'd2, 5'd1, 3'd0, 5'd0, 7'h63}, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0});
    sv.push_back('{i_t(12'hFFC, 3'd2, 7'h03), 32'h0, 32'h1000, 32'h0, 32'h0, 32'hFFC});
    sv.push_back('{r_t(7'h00, 3'd0), 32'h0, 32'hFFFFFFFF, 32'h2, 32'h1, 32'h0});
    sv.push_back('{i_t(12'h400, 3'd0, 7'h13), 32'h0, 32'h1, 32'h0, 32'h401, 32'h0});
    mv.push_back('{r_t(7'h01, 3'd0), 32'hFFFFFFFF, 32'h3, 32'hFFFFFFFD, 0});
    mv.push_back('{r_t(7'h01, 3'd3), 32'hFFFFFFFF, 32'h3, 32'h00000002, 0});
    mv.push_back('{r_t(7'h01, 3'd1), 32'h80000000, 32'h80000000, 32'h40000000, 0});
    mv.push_back('{r_t(7'h01, 3'd2), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    mv.push_back('{r_t(7'h01, 3'd4), 32'h7, 32'h0, 32'hFFFFFFFF, 3});
    mv.push_back('{r_t(7'h01, 3'd6), 32'h7, 32'h0, 32'h7, 0});
    mv.push_back('{r_t(7'h01, 3'd4), 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0});
    mv.push_back('{r_t(7'h01, 3'd6), 32'h80000000, 32'hFFFFFFFF, 32'h0, 0});
    mv.push_back('{r_t(7'h01, 3'd4), 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 0});
    mv.push_back('{r_t(7'h01, 3'd6), 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 0});
    mv.push_back('{r_t(7'h01, 3'd6), 32'h7, 32'hFFFFFFFE, 32'h1, 0});
    mv.push_back('{r_t(7'h01, 3'd5), 32'hFFFFFFF9, 32'h2, 32'h7FFFFFFC, 0});
    mv.push_back('{r_t(7'h01, 3'd7), 32'hFFFFFFF9, 32'h2, 32'h1, 0});
    mv.push_back('{r_t(7'h01, 3'd5), 32'h5, 32'h0, 32'hFFFFFFFF, 0});
    @(posedge clk);
    #2;
    chk("rst_inst", mem_inst, 32'h13);
    chk("rst_res", exe_result, 32'h0);
    chk("rst_addr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    w = i_t(12'h040, 3'd0, 7'h13);
    sc(w, 32'h100, 32'h0, 32'h0);
    chk("addi_inst", mem_inst, w);
    chk("addi_res", exe_result, 32'h40);
    chk("addi_addr", mem_addr, 32'h0);
    w = {7'h0, 5'd5, 5'd1, 3'd2, 5'd8, 7'h23};
    sc(w, 32'h104, 32'h10, 32'h20);
    chk("sw_addr", mem_addr, 32'h18);
    chk("sw_res", exe_result, 32'h20);
    @(negedge clk);
    exe_inst = r_t(7'h00, 3'd0); rs1_data = 32'h5; rs2_data = 32'h6; freeze_cpu = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #2;
      chk("frz_inst", mem_inst, w);
      chk("frz_res", exe_result, 32'h20);
    end
    @(negedge clk);
    freeze_cpu = 1'b0;
    @(posedge clk);
    #2;
    chk("unfrz_res", exe_result, 32'hB);
    foreach (sv[i]) begin
      sc(sv[i].inst, sv[i].pc, sv[i].a, sv[i].b);
      chk($sformatf("sc%0d_res", i), exe_result, sv[i].res);
      chk($sformatf("sc%0d_addr", i), mem_addr, sv[i].addr);
    end
    foreach (mv[i]) begin
      mop(mv[i].inst, mv[i].a, mv[i].b, mv[i].hold, n);
      chk($sformatf("m%0d_busy_cycles", i), n, 33);
      chk($sformatf("m%0d_inst", i), mem_inst, mv[i].inst);
      chk($sformatf("m%0d_res", i), exe_result, mv[i].res);
    end
    @(negedge clk);
    exe_inst = r_t(7'h01, 3'd0); rs1_data = 32'h1234; rs2_data = 32'h5678;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    exe_inst = 32'h13;
    @(posedge clk);
    #2;
    chk("midrst_inst", mem_inst, 32'h13);
    chk("midrst_busy", {31'b0, exe_busy}, 32'h0);
    chk("midrst_res", exe_result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    sc(i_t(12'h040, 3'd0, 7'h13), 32'h100, 32'h0, 32'h0);
    chk("postrst_res", exe_result, 32'h40);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
